// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Write-side and line-side signal bundle for uart_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 write_en;
  logic [DATA_BITS-1:0] data;
  logic                 tx;
  logic                 uart_busy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overflow;

  modport master (
    output write_en, data,
    input  tx, uart_busy, fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  write_en, data,
    output tx, uart_busy, fifo_full, fifo_empty, fifo_count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter fed by a TX FIFO; frames are sent back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int BAUD_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and occupancy
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 full_q;
  logic                 empty_q;
  logic                 ovf_q;

  // --------------------------------------------------------------------------
  // Transmitter state
  // --------------------------------------------------------------------------
  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;

  logic                 push;
  logic                 pop;
  logic                 bit_done;
  logic                 last_stop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign bit_done  = (baud_q == BAUD_W'(BIT_CLKS - 1));
  assign last_stop = (bit_q == 4'(STOP_BITS - 1));
  assign head      = mem_q[rd_ptr_q];
  assign head_par  = (^head) ^ (PARITY == 2);

  // A full FIFO refuses the write even if a pop happens in the same cycle.
  assign push = bus.write_en && !full_q;
  assign pop  = !empty_q &&
                ((state_q == S_IDLE) ||
                 (state_q == S_STOP && bit_done && last_stop));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= bus.write_en && full_q;
    end
  end

  // tx and busy are registered from the current state, so the line lags the
  // state by one clock; every bit period keeps its exact length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_q != S_IDLE);
      case (state_q)
        S_START:  tx_q <= 1'b0;
        S_DATA:   tx_q <= shift_q[0];
        S_PARITY: tx_q <= par_q;
        default:  tx_q <= 1'b1;
      endcase

      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            shift_q <= head;
            par_q   <= head_par;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (bit_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (bit_done) begin
            baud_q <= '0;
            if (last_stop) begin
              bit_q <= '0;
              // Chain straight into the next frame when data is waiting.
              if (pop) begin
                shift_q <= head;
                par_q   <= head_par;
                state_q <= S_START;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.uart_busy  = busy_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo in five configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // 0: 8N1 depth 16   1: 8E2   2: 8O1   3: 5N1   4: 8N1 depth 4 (10 clk/bit all)
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(5), .FIFO_DEPTH(16)) if3 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if4 ();

  uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                 .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .DATA_BITS(5),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u3 (.clk(clk), .rst(rst), .bus(if3));
  uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic txv(input int d);
    case (d)
      0:       return if0.tx;
      1:       return if1.tx;
      2:       return if2.tx;
      3:       return if3.tx;
      default: return if4.tx;
    endcase
  endfunction

  function automatic logic busyv(input int d);
    case (d)
      0:       return if0.uart_busy;
      1:       return if1.uart_busy;
      2:       return if2.uart_busy;
      3:       return if3.uart_busy;
      default: return if4.uart_busy;
    endcase
  endfunction

  // Waits (bounded) for the line to drop low; ok=0 if it never does.
  task automatic wait_start(input int d, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (txv(d) === 1'b0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Records nbits line bits starting at the first cycle of a start bit; a bit
  // is marked stable only if it held its value for all bclk cycles.
  task automatic capture(input int d, input int nbits, input int bclk,
                         output logic [63:0] bits, output logic [63:0] stable,
                         output logic busy_min);
    logic v;
    bits     = '0;
    stable   = '0;
    busy_min = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < bclk; c++) begin
        v = txv(d);
        if (busyv(d) !== 1'b1) busy_min = 1'b0;
        if (c == 0) begin
          bits[i]   = v;
          stable[i] = 1'b1;
        end else if (v !== bits[i]) begin
          stable[i] = 1'b0;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (if0.tx !== 1'b1 || if0.uart_busy !== 1'b0 || if0.fifo_empty !== 1'b1 ||
        if0.fifo_full !== 1'b0 || if0.fifo_count !== 5'd0 || if0.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_u0: tx=%b busy=%b empty=%b full=%b count=%0d ovf=%b expected 1 0 1 0 0 0",
               if0.tx, if0.uart_busy, if0.fifo_empty, if0.fifo_full, if0.fifo_count, if0.overflow);
    end
    checks++;
    if (if4.tx !== 1'b1 || if4.fifo_empty !== 1'b1 || if4.fifo_count !== 3'd0 || if4.fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_u4: tx=%b empty=%b count=%0d full=%b expected 1 1 0 0",
               if4.tx, if4.fifo_empty, if4.fifo_count, if4.fifo_full);
    end
  endtask

  task automatic test_basic;
    logic [63:0] bits, stable;
    logic        bmin;
    if0.write_en = 1'b1;
    if0.data     = 8'hA5;
    tick();
    if0.write_en = 1'b0;
    checks++;
    if (if0.fifo_empty !== 1'b0 || if0.fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL basic_after_write: empty=%b count=%0d expected 0 1", if0.fifo_empty, if0.fifo_count);
    end
    tick();
    checks++;
    if (if0.fifo_empty !== 1'b1 || if0.tx !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_pop: empty=%b tx=%b expected 1 1", if0.fifo_empty, if0.tx);
    end
    tick();
    checks++;
    if (if0.tx !== 1'b0 || if0.uart_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: tx=%b busy=%b expected 0 1", if0.tx, if0.uart_busy);
    end
    capture(0, 10, 10, bits, stable, bmin);
    checks++;
    if (bits[9:0] !== 10'b1_1010_0101_0) begin
      errors++;
      $display("FAIL basic_bits: got %b expected %b", bits[9:0], 10'b1_1010_0101_0);
    end
    checks++;
    if (stable[9:0] !== 10'h3FF || bmin !== 1'b1) begin
      errors++;
      $display("FAIL basic_timing: stable=%b busy_held=%b expected %b 1", stable[9:0], bmin, 10'h3FF);
    end
    checks++;
    if (if0.tx !== 1'b1 || if0.uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: tx=%b busy=%b expected 1 0", if0.tx, if0.uart_busy);
    end
  endtask

  task automatic test_parity;
    logic [63:0] bits, stable;
    logic        bmin;
    bit          ok;
    // even parity, two stop bits, 0xA5 (four ones -> parity 0), 120 clocks
    if1.write_en = 1'b1; if1.data = 8'hA5; tick(); if1.write_en = 1'b0;
    wait_start(1, 5, ok);
    capture(1, 12, 10, bits, stable, bmin);
    checks++;
    if (!ok || bits[11:0] !== 12'b11_0_1010_0101_0 || stable[11:0] !== 12'hFFF || bmin !== 1'b1) begin
      errors++;
      $display("FAIL parity_even_a5: started=%0d bits=%b stable=%b expected %b",
               ok, bits[11:0], stable[11:0], 12'b11_0_1010_0101_0);
    end
    checks++;
    if (if1.tx !== 1'b1 || if1.uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL parity_even_len: tx=%b busy=%b after 120 clocks expected 1 0", if1.tx, if1.uart_busy);
    end
    // even parity, 0x01 -> parity 1
    if1.write_en = 1'b1; if1.data = 8'h01; tick(); if1.write_en = 1'b0;
    wait_start(1, 5, ok);
    capture(1, 12, 10, bits, stable, bmin);
    checks++;
    if (!ok || bits[11:0] !== 12'b11_1_0000_0001_0 || stable[11:0] !== 12'hFFF) begin
      errors++;
      $display("FAIL parity_even_01: started=%0d bits=%b expected %b",
               ok, bits[11:0], 12'b11_1_0000_0001_0);
    end
    // odd parity, one stop bit, 0xA5 -> parity 1
    if2.write_en = 1'b1; if2.data = 8'hA5; tick(); if2.write_en = 1'b0;
    wait_start(2, 5, ok);
    capture(2, 11, 10, bits, stable, bmin);
    checks++;
    if (!ok || bits[10:0] !== 11'b1_1_1010_0101_0 || stable[10:0] !== 11'h7FF) begin
      errors++;
      $display("FAIL parity_odd_a5: started=%0d bits=%b expected %b",
               ok, bits[10:0], 11'b1_1_1010_0101_0);
    end
  endtask

  task automatic test_data5;
    logic [63:0] bits, stable;
    logic        bmin;
    bit          ok;
    if3.write_en = 1'b1; if3.data = 5'h1B; tick(); if3.write_en = 1'b0;
    wait_start(3, 5, ok);
    capture(3, 7, 10, bits, stable, bmin);
    checks++;
    if (!ok || bits[6:0] !== 7'b1_11011_0 || stable[6:0] !== 7'h7F) begin
      errors++;
      $display("FAIL data5_bits: started=%0d bits=%b expected %b", ok, bits[6:0], 7'b1_11011_0);
    end
    checks++;
    if (if3.tx !== 1'b1 || if3.uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL data5_len: tx=%b busy=%b after 70 clocks expected 1 0", if3.tx, if3.uart_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] bits, stable;
    logic        bmin;
    bit          ok;
    if0.write_en = 1'b1; if0.data = 8'h55; tick();
    if0.data = 8'h0F; tick();
    checks++;
    if (if0.fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL b2b_count1: count=%0d expected 1", if0.fifo_count);
    end
    if0.data = 8'hF0; tick();
    if0.write_en = 1'b0;
    checks++;
    if (if0.fifo_count !== 5'd2) begin
      errors++;
      $display("FAIL b2b_count_peak: count=%0d expected 2", if0.fifo_count);
    end
    wait_start(0, 5, ok);
    capture(0, 30, 10, bits, stable, bmin);
    checks++;
    if (!ok || bits[29:0] !== {1'b1, 8'hF0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0} ||
        stable[29:0] !== 30'h3FFF_FFFF || bmin !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bits: started=%0d bits=%b stable=%b busy_held=%b expected %b",
               ok, bits[29:0], stable[29:0], bmin,
               {1'b1, 8'hF0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0});
    end
    checks++;
    if (if0.tx !== 1'b1 || if0.uart_busy !== 1'b0 || if0.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: tx=%b busy=%b empty=%b expected 1 0 1", if0.tx, if0.uart_busy, if0.fifo_empty);
    end
  endtask

  task automatic test_overflow;
    logic [63:0] bits, stable;
    logic        bmin;
    bit          ok;
    int          pulses;
    pulses = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if4.write_en = 1'b1;
          if4.data     = 8'(8'h11 * (i + 1));
          tick();
          if (if4.overflow === 1'b1) pulses++;
          if (i == 4) begin
            checks++;
            if (if4.fifo_full !== 1'b1 || if4.fifo_count !== 3'd4 || if4.overflow !== 1'b0) begin
              errors++;
              $display("FAIL ovf_full: full=%b count=%0d ovf=%b expected 1 4 0",
                       if4.fifo_full, if4.fifo_count, if4.overflow);
            end
          end
          if (i == 5) begin
            checks++;
            if (if4.overflow !== 1'b1 || if4.fifo_count !== 3'd4) begin
              errors++;
              $display("FAIL ovf_pulse: ovf=%b count=%0d expected 1 4", if4.overflow, if4.fifo_count);
            end
          end
        end
        if4.write_en = 1'b0;
        for (int n = 0; n < 20; n++) begin
          tick();
          if (if4.overflow === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
          errors++;
          $display("FAIL ovf_pulse_count: pulses=%0d expected 1", pulses);
        end
      end
      begin
        wait_start(4, 10, ok);
        capture(4, 50, 10, bits, stable, bmin);
      end
    join
    checks++;
    if (!ok || bits[49:0] !== {1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0,
                               1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0} ||
        stable[49:0] !== {50{1'b1}}) begin
      errors++;
      $display("FAIL ovf_line: started=%0d bits=%b expected %b", ok, bits[49:0],
               {1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0});
    end
    checks++;
    if (if4.tx !== 1'b1 || if4.uart_busy !== 1'b0 || if4.fifo_empty !== 1'b1 || if4.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL ovf_end: tx=%b busy=%b empty=%b count=%0d expected 1 0 1 0",
               if4.tx, if4.uart_busy, if4.fifo_empty, if4.fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit quiet;
    if0.write_en = 1'b1; if0.data = 8'h3C; tick();
    if0.data = 8'hC3; tick();
    if0.data = 8'h5A; tick();
    if0.write_en = 1'b0;
    repeat (30) tick();
    checks++;
    if (if0.uart_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_before: busy=%b expected 1", if0.uart_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (if0.tx !== 1'b1 || if0.uart_busy !== 1'b0 || if0.fifo_count !== 5'd0 || if0.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after: tx=%b busy=%b count=%0d empty=%b expected 1 0 0 1",
               if0.tx, if0.uart_busy, if0.fifo_count, if0.fifo_empty);
    end
    quiet = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (if0.tx !== 1'b1 || if0.uart_busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_quiet: line active after reset without writes (quiet=%b expected 1)", quiet);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if0.write_en = 1'b0; if0.data = '0;
    if1.write_en = 1'b0; if1.data = '0;
    if2.write_en = 1'b0; if2.data = '0;
    if3.write_en = 1'b0; if3.data = '0;
    if4.write_en = 1'b0; if4.data = '0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_parity();
    test_data5();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a built-in TX FIFO, configurable data width, parity and stop-bit count. It is the successor to the single-byte transmitter. Writers no longer need to poll busy per byte: bytes are queued and sent back-to-back with no idle gap. It sits between the CPU-side MMIO UART register and the board TX pin.

Parameters:
CLK_FREQ, 10_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; one bit period = BIT_CLKS = CLK_FREQ/BAUD clocks (integer division)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of two, minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
write_en  input  1  push data into the FIFO this cycle
data  input  DATA_BITS  word to push
tx  output  1  serial line, idle high
uart_busy  output  1  high while a frame is on the line (state != IDLE)
fifo_full  output  1  FIFO holds FIFO_DEPTH words
fifo_empty  output  1  FIFO holds 0 words
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse: write_en while fifo_full, word dropped

Behaviour:
- Reset (sync, rst high at a clock edge): tx=1, uart_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0. FIFO pointers cleared, queued data discarded. State=IDLE, counters zeroed. Reset mid-frame aborts the frame: tx is high from the cycle after the reset edge.
- FIFO: a write occurs when write_en && !fifo_full. A write attempted while full is dropped and overflow pulses on the next cycle. A pop in the same cycle does NOT make room for a write issued while full. Simultaneous write and pop when not full or empty leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH. All flags and fifo_count are registered and reflect the state after the edge.
- tx is registered, driven from the state machine or shift register, glitch-free.
- Bit timing: baud counter 0..BIT_CLKS-1. Every bit, including each stop bit, is exactly BIT_CLKS clocks.
- State machine:
  - IDLE: tx=1. If !fifo_empty, pop the head word into the shift register, compute parity, go to START.
  - START: tx=0 for one bit period, then DATA.
  - DATA: LSB first, DATA_BITS bit periods. Then PARITY if PARITY!=0, else STOP.
  - PARITY: tx = XOR of the data bits for even parity, inverted for odd parity. One bit period, then STOP.
  - STOP: tx=1 for STOP_BITS bit periods. On the last clock of the final stop bit: if !fifo_empty, pop and go directly to START (no idle cycles between frames); else go to IDLE.
- Latency: write at edge t into an empty FIFO while IDLE → fifo_empty=0 after t, pop at t+1, tx=0 from t+2.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BIT_CLKS clocks.
- uart_busy is high from the cycle tx first goes low until the state returns to IDLE.
- Upper data bits beyond DATA_BITS do not exist; the port width equals DATA_BITS.

Test Plan:
- Basic 8N1 frame: CLK_FREQ=10_000_000, BAUD=1_000_000 (10 clk/bit); write 0xA5 once → tx bit sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit exactly 10 clocks; uart_busy high for 100 clocks; fifo_empty back to 1 one cycle after write.
- Parity and stop: PARITY=1, STOP_BITS=2, send 0xA5 → parity bit 0, frame 120 clocks. PARITY=2 → parity bit 1. Send 0x01 with even parity → parity bit 1.
- Back-to-back: write 0x55, 0x0F, 0xF0 on consecutive cycles → three frames with no idle cycle between stop and next start; fifo_count peaks at 2; after the last frame uart_busy=0 and tx=1.
- Full/overflow: FIFO_DEPTH=4, write 6 words in 6 consecutive cycles while the first is transmitting → fifo_full=1 with fifo_count=4. Exactly one word (the sixth) is dropped; overflow pulses once for one cycle. Only words 1-5 appear on the line, in order.
- Reset mid-frame: assert rst during the data bits of a frame with 3 words queued → tx=1, uart_busy=0, fifo_count=0 the cycle after; no further frames without new writes.
- DATA_BITS=5, PARITY=0: send 0x1B → tx sequence 0,1,1,0,1,1,1, i.e. 7 bit periods total.
